// File: rtl/risc_boot_loader_pkg.sv
// risc_defs: shared constants for the risc_machine boot path.
// Holds memory geometry, loader state encodings and header field positions.
package risc_defs;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int DATA_W    = 16;

    // Header word: [15:8] base address, [7:0] word count minus one.
    localparam int HDR_BASE_MSB = 15;
    localparam int HDR_BASE_LSB = 8;
    localparam int HDR_CNT_MSB  = 7;
    localparam int HDR_CNT_LSB  = 0;

    typedef enum logic [2:0] {
        LD_HDR  = 3'd0,
        LD_DATA = 3'd1,
        LD_CSUM = 3'd2,
        LD_RUN  = 3'd3,
        LD_ERR  = 3'd4
    } ld_state_e;

endpackage

// File: rtl/risc_boot_loader_csum_acc.sv
// loader_csum_acc: 16-bit running sum of frame data words, carries dropped.
// Only built when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
module loader_csum_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_add,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] r_sum;

    // Clear on a new header, otherwise accumulate each accepted data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule
`endif

// File: rtl/risc_boot_loader.sv
// risc_boot_loader: framed word stream -> risc_machine memory, CPU held until loaded.
// Optional checksum word and ERR state when LOADER_CHECKSUM_EN is defined.
module risc_boot_loader #(
    parameter int ADDR_W = risc_defs::ADDR_W,
    parameter int DATA_W = risc_defs::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    import risc_defs::*;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_e LD_AFTER_DATA = LD_CSUM;
`else
    localparam ld_state_e LD_AFTER_DATA = LD_RUN;
`endif

    ld_state_e         r_state;
    ld_state_e         w_next;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_k;
    logic              w_xfer;
    logic              w_hdr_acc;
    logic              w_data_acc;
    logic              w_last;

    // load_req beats a coincident transfer, so the word is simply dropped.
    assign w_xfer     = in_valid & r_in_ready & ~load_req;
    assign w_hdr_acc  = w_xfer & (r_state == LD_HDR);
    assign w_data_acc = w_xfer & (r_state == LD_DATA);
    assign w_last     = (r_k == r_last);

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] w_sum;
    logic              w_csum_acc;
    logic              w_csum_ok;
    logic              r_err;

    assign w_csum_acc = w_xfer & (r_state == LD_CSUM);
    assign w_csum_ok  = (in_data == w_sum);

    loader_csum_acc #(
        .W(DATA_W)
    ) u_csum (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_hdr_acc),
        .i_add (w_data_acc),
        .i_data(in_data),
        .o_sum (w_sum)
    );

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LD_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: load_req restarts from any state.
    always_comb begin
        w_next = r_state;
        if (load_req) begin
            w_next = LD_HDR;
        end else begin
            unique case (r_state)
                LD_HDR: begin
                    if (w_hdr_acc) w_next = LD_DATA;
                end
                LD_DATA: begin
                    if (w_data_acc && w_last) w_next = LD_AFTER_DATA;
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CSUM: begin
                    if (w_csum_acc) w_next = w_csum_ok ? LD_RUN : LD_ERR;
                end
`endif
                LD_RUN, LD_ERR: begin
                    w_next = r_state;
                end
                default: begin
                    w_next = LD_HDR;
                end
            endcase
        end
    end

    // Frame bookkeeping: latch base/count on header, step offset per data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_last <= '0;
            r_k    <= '0;
        end else if (w_hdr_acc) begin
            r_base <= in_data[HDR_BASE_MSB:HDR_BASE_LSB];
            r_last <= in_data[HDR_CNT_MSB:HDR_CNT_LSB];
            r_k    <= '0;
        end else if (w_data_acc) begin
            r_k <= r_k + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Registered outputs, derived from next-state so ready drops with the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_in_ready <= (w_next == LD_HDR)
                       || (w_next == LD_DATA)
                       || (w_next == LD_CSUM);
            r_mem_we   <= w_data_acc;
            if (w_data_acc) begin
                // Base plus offset wraps naturally at the address width.
                r_mem_addr  <= r_base + r_k;
                r_mem_wdata <= in_data;
            end
            r_cpu_hold <= (w_next != LD_RUN);
            r_done     <= (w_next == LD_RUN);
`ifdef LOADER_CHECKSUM_EN
            r_err      <= (w_next == LD_ERR);
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;

endmodule

// File: tb/tb_risc_boot_loader.sv
// tb_risc_boot_loader: random framed loads against a memory-image model.
// Expected writes go to a queue; a negedge monitor pops and compares them.
module tb_risc_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        load_req = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    risc_boot_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .load_req (load_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;
    logic [15:0] model_img[256];
    logic [15:0] dut_img[256];
    logic [15:0] fw[256];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: got %h:%h expected none",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_e) begin
                    miscompares++;
                    $display("FAIL wr_data: got %h:%h expected %h:%h",
                             mem_addr, mem_wdata, mon_e[23:16], mon_e[15:0]);
                end
            end
            dut_img[mem_addr] = mem_wdata;
        end
    end

    task automatic send(input logic [15:0] w, input int gap);
        int g;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        g = 0;
        while (in_ready !== 1'b1 && g < 64) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_we"},    {31'b0, mem_we},   32'd0);
        chk({tag, "_addr"},  {24'b0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'b0, mem_wdata}, 32'd0);
        chk({tag, "_hold"},  {31'b0, cpu_hold}, 32'd1);
        chk({tag, "_done"},  {31'b0, done},     32'd0);
        chk({tag, "_err"},   {31'b0, err},      32'd0);
    endtask

    // Sends header, fw[0..n-1], and (if built) sum ^ cs_xor as checksum.
    task automatic send_frame(input logic [7:0] base, input int n,
                              input int maxgap, input logic [15:0] cs_xor);
        logic [15:0] sum;
        logic [7:0]  a;
        logic        bad;
        sum = 16'h0;
        send({base, 8'(n - 1)}, $urandom_range(0, maxgap));
        for (int k = 0; k < n; k++) begin
            a = base + 8'(k);
            exp_q.push_back({a, fw[k]});
            model_img[a] = fw[k];
            sum = sum + fw[k];
            send(fw[k], $urandom_range(0, maxgap));
        end
`ifdef LOADER_CHECKSUM_EN
        bad = (cs_xor != 16'h0);
        send(sum ^ cs_xor, $urandom_range(0, maxgap));
`else
        bad = 1'b0 & (|cs_xor);
`endif
        in_valid = 1'b0;
        chk("end_done",  {31'b0, done},     {31'b0, ~bad});
        chk("end_hold",  {31'b0, cpu_hold}, {31'b0, bad});
        chk("end_err",   {31'b0, err},      {31'b0, bad});
        chk("end_ready", {31'b0, in_ready}, 32'd0);
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        chk("req_ready", {31'b0, in_ready}, 32'd1);
        chk("req_done",  {31'b0, done},     32'd0);
        chk("req_hold",  {31'b0, cpu_hold}, 32'd1);
        chk("req_err",   {31'b0, err},      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [7:0]  a;
        logic [15:0] x;
        int          n;
        for (int i = 0; i < 256; i++) begin
            model_img[i] = 16'h0;
            dut_img[i]   = 16'h0;
        end

        // Reset values, then ready rises on the first edge after release.
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_pre", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready_post", {31'b0, in_ready}, 32'd1);

        // Basic three-word frame at 0x10.
        fw[0] = 16'hAAAA;
        fw[1] = 16'hBBBB;
        fw[2] = 16'hCCCC;
        send_frame(8'h10, 3, 0, 16'h0);
        pulse_req();

        // Wrap from 0xFF to 0x00.
        for (int k = 0; k < 4; k++) fw[k] = 16'($urandom);
        send_frame(8'hFE, 4, 2, 16'h0);
        pulse_req();

        // Data 0x1234 with checksum 0x0000 (mismatch when checksumming).
        fw[0] = 16'h1234;
        send_frame(8'h00, 1, 0, 16'h1234);
        pulse_req();

        // Abort after 2 of 5 words; third word coincides with load_req.
        send(16'h3004, 0);
        for (int k = 0; k < 2; k++) begin
            x = 16'($urandom);
            a = 8'h30 + 8'(k);
            exp_q.push_back({a, x});
            model_img[a] = x;
            send(x, 0);
        end
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        in_valid = 1'b0;
        chk("abort_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_done",  {31'b0, done},     32'd0);
        chk("abort_hold",  {31'b0, cpu_hold}, 32'd1);
        fw[0] = 16'($urandom);
        send_frame(8'h20, 1, 1, 16'h0);
        pulse_req();

        // Reset mid-DATA, then a full frame.
        send(16'h4005, 0);
        for (int k = 0; k < 3; k++) begin
            x = 16'($urandom);
            a = 8'h40 + 8'(k);
            exp_q.push_back({a, x});
            model_img[a] = x;
            send(x, 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) fw[k] = 16'($urandom);
        send_frame(8'h40, 6, 3, 16'h0);
        pulse_req();

        // Randomized frames, gaps and occasional bad checksums.
        for (int f = 0; f < 12; f++) begin
            n = (f == 5) ? 256 : $urandom_range(1, 40);
            b = 8'($urandom);
            for (int k = 0; k < n; k++) fw[k] = 16'($urandom);
            x = ($urandom_range(0, 3) == 0) ? (16'($urandom) | 16'h1) : 16'h0;
            send_frame(b, n, (f % 3), x);
            pulse_req();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        for (int i = 0; i < 256; i++) begin
            chk("mem_img", {8'(i), dut_img[i]}, {8'(i), model_img[i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
